// File: rtl/jtframe_ioctl_upload.sv
// jtframe_ioctl_upload: serves SD-card upload byte reads from SDRAM through a two-word cache
module jtframe_ioctl_upload #(
   parameter int         SDRAMW    = 23,
   parameter logic [1:0] RAM_BA    = 2'd0,
   parameter int         RAM_START = 0,
   parameter int         RAM_LEN   = 32768
)(
   input  logic              clk_sys,
   input  logic              rst,
   input  logic              ioctl_ram,
   input  logic              ioctl_rd,
   input  logic [24:0]       ioctl_addr,
   output logic [7:0]        ioctl_data2sd,
   output logic              rd_ack,
   output logic [SDRAMW-1:0] prog_addr,
   output logic [1:0]        prog_ba,
   output logic              prog_rd,
   input  logic              prog_ack,
   input  logic              prog_rdy,
   input  logic [15:0]       sdram_dout
);
   localparam logic [2:0]  IDLE = 3'd0, REQ = 3'd1, WAIT = 3'd2, PREQ = 3'd3, PWAIT = 3'd4;
   localparam logic [31:0] LEN   = RAM_LEN;
   localparam logic [31:0] START = RAM_START;
   logic [2:0]        r_st;
   logic              r_cur_v, r_nxt_v, r_pend, r_drop, r_sel, r_ack, r_prog_rd;
   logic [23:0]       r_cur_a, r_nxt_a, r_fa;
   logic [15:0]       r_cur_d, r_nxt_d;
   logic [24:0]       r_pend_a;
   logic [7:0]        r_dout;
   logic [SDRAMW-1:0] r_prog_addr;
   logic              w_go, w_oor, w_hit_c, w_hit_n, w_keep;
   logic [24:0]       w_a;
   logic [23:0]       w_wa;
   function automatic logic [SDRAMW-1:0] f_pa(input logic [23:0] wa);
      logic [31:0] s;
      s = START + {8'd0, wa};
      return s[SDRAMW-1:0];
   endfunction
   // a prefetch is only worth issuing when the following word is still inside the region
   function automatic logic f_pf(input logic [23:0] wa);
      return ({7'd0, wa, 1'b0} + 32'd2) < LEN;
   endfunction
   function automatic logic [7:0] f_b(input logic [15:0] d, input logic s);
      return s ? d[15:8] : d[7:0];
   endfunction
   assign ioctl_data2sd = r_dout;
   assign rd_ack        = r_ack;
   assign prog_addr     = r_prog_addr;
   assign prog_ba       = RAM_BA;
   assign prog_rd       = r_prog_rd;
   // read request evaluation: a request latched during a prefetch takes priority
   always_comb begin
      w_go    = ioctl_ram & (r_pend | ioctl_rd);
      w_a     = r_pend ? r_pend_a : ioctl_addr;
      w_wa    = w_a[24:1];
      w_oor   = {7'd0, w_a} >= LEN;
      w_hit_c = r_cur_v && r_cur_a == w_wa;
      w_hit_n = r_nxt_v && r_nxt_a == w_wa;
      w_keep  = ioctl_ram & ~r_drop;
   end
   // cache, fetch FSM and SDRAM handshake
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         r_st        <= IDLE;
         r_cur_v     <= 1'b0;
         r_nxt_v     <= 1'b0;
         r_pend      <= 1'b0;
         r_drop      <= 1'b0;
         r_sel       <= 1'b0;
         r_ack       <= 1'b0;
         r_prog_rd   <= 1'b0;
         r_cur_a     <= '0;
         r_nxt_a     <= '0;
         r_fa        <= '0;
         r_cur_d     <= '0;
         r_nxt_d     <= '0;
         r_pend_a    <= '0;
         r_dout      <= '0;
         r_prog_addr <= '0;
      end else begin
         r_ack <= 1'b0;
         if (!ioctl_ram) begin
            r_cur_v <= 1'b0;
            r_nxt_v <= 1'b0;
            r_pend  <= 1'b0;
            if (r_st != IDLE) r_drop <= 1'b1;
         end
         case (r_st)
            IDLE: begin
               r_drop <= 1'b0;
               if (w_go) begin
                  r_pend <= 1'b0;
                  if (w_oor) begin
                     r_dout <= 8'hFF;
                     r_ack  <= 1'b1;
                  end else if (w_hit_c) begin
                     r_dout <= f_b(r_cur_d, w_a[0]);
                     r_ack  <= 1'b1;
                  end else if (w_hit_n) begin
                     r_dout  <= f_b(r_nxt_d, w_a[0]);
                     r_ack   <= 1'b1;
                     r_cur_v <= 1'b1;
                     r_cur_a <= r_nxt_a;
                     r_cur_d <= r_nxt_d;
                     r_nxt_v <= 1'b0;
                     if (f_pf(r_nxt_a)) begin
                        r_fa        <= r_nxt_a + 24'd1;
                        r_prog_addr <= f_pa(r_nxt_a + 24'd1);
                        r_prog_rd   <= 1'b1;
                        r_st        <= PREQ;
                     end
                  end else begin
                     r_cur_v     <= 1'b0;
                     r_nxt_v     <= 1'b0;
                     r_sel       <= w_a[0];
                     r_fa        <= w_wa;
                     r_prog_addr <= f_pa(w_wa);
                     r_prog_rd   <= 1'b1;
                     r_st        <= REQ;
                  end
               end
            end
            REQ, PREQ: if (prog_ack) begin
               r_prog_rd <= 1'b0;
               r_st      <= r_st == REQ ? WAIT : PWAIT;
            end
            WAIT: if (prog_rdy) begin
               r_st <= IDLE;
               if (w_keep) begin
                  r_cur_v <= 1'b1;
                  r_cur_a <= r_fa;
                  r_cur_d <= sdram_dout;
                  r_dout  <= f_b(sdram_dout, r_sel);
                  r_ack   <= 1'b1;
                  if (f_pf(r_fa)) begin
                     r_fa        <= r_fa + 24'd1;
                     r_prog_addr <= f_pa(r_fa + 24'd1);
                     r_prog_rd   <= 1'b1;
                     r_st        <= PREQ;
                  end
               end
            end
            PWAIT: if (prog_rdy) begin
               r_st <= IDLE;
               if (w_keep) begin
                  r_nxt_v <= 1'b1;
                  r_nxt_a <= r_fa;
                  r_nxt_d <= sdram_dout;
               end
            end
            default: r_st <= IDLE;
         endcase
         if ((r_st == PREQ || r_st == PWAIT) && ioctl_rd && ioctl_ram) begin
            r_pend   <= 1'b1;
            r_pend_a <= ioctl_addr;
         end
      end
   end
endmodule

// File: tb/tb_jtframe_ioctl_upload.sv
// tb_jtframe_ioctl_upload: directed checks of the upload cache against a scripted SDRAM model
module tb_jtframe_ioctl_upload;
   logic        clk = 1'b0, rst = 1'b1, ioctl_ram = 1'b1, ioctl_rd = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_data2sd;
   logic        rd_ack, prog_rd, prog_ack, prog_rdy;
   logic [22:0] prog_addr;
   logic [1:0]  prog_ba;
   logic [15:0] sdram_dout;
   int nv = 0, nf = 0, n_ack = 0, viol = 0, ack_dly = 0, rdy_dly = 0;
   logic [22:0] req_q[$];
   jtframe_ioctl_upload #(.SDRAMW(23), .RAM_BA(2'd2), .RAM_START(256), .RAM_LEN(32768)) dut (
      .clk_sys(clk), .rst(rst), .ioctl_ram(ioctl_ram), .ioctl_rd(ioctl_rd),
      .ioctl_addr(ioctl_addr), .ioctl_data2sd(ioctl_data2sd), .rd_ack(rd_ack),
      .prog_addr(prog_addr), .prog_ba(prog_ba), .prog_rd(prog_rd), .prog_ack(prog_ack),
      .prog_rdy(prog_rdy), .sdram_dout(sdram_dout));
   always #5 clk = ~clk;
   function automatic logic [15:0] mem(input logic [22:0] wa);
      return wa == 23'd0 ? 16'h1234 : wa == 23'd1 ? 16'hABCD : {wa[7:0] ^ 8'h5A, wa[7:0]};
   endfunction
   always @(posedge clk) begin
      #1;
      if (rd_ack === 1'b1) n_ack++;
   end
   initial begin
      logic [22:0] a;
      prog_ack = 0; prog_rdy = 0; sdram_dout = 0;
      forever begin
         @(negedge clk);
         prog_rdy = 0;
         if (prog_rd === 1'b1) begin
            a = prog_addr;
            req_q.push_back(a);
            repeat (ack_dly) @(negedge clk);
            prog_ack = 1;
            @(negedge clk);
            prog_ack = 0;
            for (int i = 0; i < rdy_dly; i++) begin
               if (prog_rd !== 1'b0) viol++;
               @(negedge clk);
            end
            if (prog_rd !== 1'b0) viol++;
            prog_rdy   = 1;
            sdram_dout = mem(a - 23'd256);
         end
      end
   end
   task automatic do_rd(input logic [24:0] a, output logic [7:0] d, output int cyc);
      ioctl_addr = a;
      ioctl_rd   = 1;
      @(negedge clk);
      ioctl_rd = 0;
      cyc = 1;
      while (rd_ack !== 1'b1 && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
      d = ioctl_data2sd;
   endtask
   task automatic test_reset;
      repeat (3) @(negedge clk);
      rst = 0;
      nv++; if (rd_ack !== 1'b0) begin nf++; $display("FAIL reset_ack got %b want 0", rd_ack); end
      nv++; if (prog_rd !== 1'b0) begin nf++; $display("FAIL reset_prog_rd got %b want 0", prog_rd); end
      nv++; if (ioctl_data2sd !== 8'h00) begin nf++; $display("FAIL reset_data got %h want 00", ioctl_data2sd); end
      nv++; if (prog_addr !== 23'd0) begin nf++; $display("FAIL reset_prog_addr got %h want 0", prog_addr); end
      nv++; if (prog_ba !== 2'd2) begin nf++; $display("FAIL reset_prog_ba got %0d want 2", prog_ba); end
   endtask
   task automatic test_miss;
      logic [7:0] d; int cyc, s;
      ack_dly = 2; rdy_dly = 3; s = n_ack;
      do_rd(25'd0, d, cyc);
      nv++; if (d !== 8'h34 || cyc != 8) begin nf++; $display("FAIL miss_rd0 data=%h cyc=%0d want 34/8", d, cyc); end
      repeat (20) @(negedge clk);
      nv++; if (n_ack - s != 1) begin nf++; $display("FAIL miss_one_ack got %0d want 1", n_ack - s); end
      nv++; if (req_q.size() != 2 || req_q[0] !== 23'h100 || req_q[1] !== 23'h101) begin
         nf++; $display("FAIL miss_prefetch reqs=%0d a0=%h a1=%h want 2/100/101", req_q.size(), req_q[0], req_q[1]);
      end
   endtask
   task automatic test_hits;
      logic [7:0] d; int cyc;
      do_rd(25'd1, d, cyc);
      nv++; if (d !== 8'h12 || cyc != 1) begin nf++; $display("FAIL hit_cur_rd1 data=%h cyc=%0d want 12/1", d, cyc); end
      do_rd(25'd2, d, cyc);
      nv++; if (d !== 8'hCD || cyc != 1) begin nf++; $display("FAIL hit_nxt_rd2 data=%h cyc=%0d want CD/1", d, cyc); end
      repeat (20) @(negedge clk);
      nv++; if (req_q.size() != 3 || req_q[2] !== 23'h102) begin
         nf++; $display("FAIL hit_nxt_prefetch reqs=%0d a=%h want 3/102", req_q.size(), req_q[2]);
      end
      do_rd(25'd3, d, cyc);
      nv++; if (d !== 8'hAB || cyc != 1) begin nf++; $display("FAIL hit_cur_rd3 data=%h cyc=%0d want AB/1", d, cyc); end
      do_rd(25'd4, d, cyc);
      nv++; if (d !== 8'h02 || cyc != 1) begin nf++; $display("FAIL hit_nxt_rd4 data=%h cyc=%0d want 02/1", d, cyc); end
      repeat (20) @(negedge clk);
      nv++; if (req_q.size() != 4 || req_q[3] !== 23'h103) begin
         nf++; $display("FAIL hit_nxt_prefetch2 reqs=%0d a=%h want 4/103", req_q.size(), req_q[3]);
      end
   endtask
   task automatic test_oor;
      logic [7:0] d; int cyc, s;
      s = req_q.size();
      do_rd(25'd32768, d, cyc);
      nv++; if (d !== 8'hFF || cyc != 1) begin nf++; $display("FAIL oor_rd data=%h cyc=%0d want FF/1", d, cyc); end
      repeat (10) @(negedge clk);
      nv++; if (req_q.size() != s) begin nf++; $display("FAIL oor_no_sdram reqs=%0d want %0d", req_q.size(), s); end
      do_rd(25'd32767, d, cyc);
      nv++; if (d !== 8'hA5 || cyc != 8) begin nf++; $display("FAIL last_byte data=%h cyc=%0d want A5/8", d, cyc); end
      repeat (20) @(negedge clk);
      nv++; if (req_q.size() != s + 1 || req_q[s] !== 23'h40FF) begin
         nf++; $display("FAIL last_no_prefetch reqs=%0d a=%h want %0d/40FF", req_q.size(), req_q[s], s + 1);
      end
   endtask
   task automatic test_ram_off;
      int s, q;
      s = n_ack; q = req_q.size();
      ioctl_ram = 0;
      @(negedge clk);
      ioctl_addr = 25'd0; ioctl_rd = 1;
      @(negedge clk);
      ioctl_rd = 0;
      repeat (10) @(negedge clk);
      ioctl_ram = 1;
      @(negedge clk);
      nv++; if (n_ack != s || req_q.size() != q) begin
         nf++; $display("FAIL ram_off_ignored acks=%0d reqs=%0d want %0d/%0d", n_ack - s, req_q.size(), 0, q);
      end
   endtask
   task automatic test_drop;
      logic [7:0] d; int cyc, s, q;
      ack_dly = 0; rdy_dly = 6; s = n_ack; q = req_q.size();
      ioctl_addr = 25'd10; ioctl_rd = 1;
      @(negedge clk);
      ioctl_rd = 0;
      repeat (2) @(negedge clk);
      ioctl_ram = 0;
      repeat (15) @(negedge clk);
      nv++; if (n_ack != s) begin nf++; $display("FAIL drop_no_ack got %0d acks want 0", n_ack - s); end
      nv++; if (req_q.size() != q + 1 || prog_rd !== 1'b0) begin
         nf++; $display("FAIL drop_no_prefetch reqs=%0d prog_rd=%b want %0d/0", req_q.size(), prog_rd, q + 1);
      end
      ioctl_ram = 1;
      @(negedge clk);
      do_rd(25'd11, d, cyc);
      nv++; if (d !== 8'h5F || cyc != 9) begin nf++; $display("FAIL drop_discard data=%h cyc=%0d want 5F/9", d, cyc); end
      repeat (20) @(negedge clk);
      do_rd(25'd0, d, cyc);
      nv++; if (d !== 8'h34 || cyc != 9) begin nf++; $display("FAIL drop_rd0_miss data=%h cyc=%0d want 34/9", d, cyc); end
      repeat (20) @(negedge clk);
   endtask
   task automatic test_pend;
      logic [7:0] d; int cyc, s;
      ack_dly = 0; rdy_dly = 10; s = n_ack;
      do_rd(25'd20, d, cyc);
      nv++; if (d !== 8'h0A || cyc != 13) begin nf++; $display("FAIL pend_miss data=%h cyc=%0d want 0A/13", d, cyc); end
      repeat (2) @(negedge clk);
      do_rd(25'd22, d, cyc);
      nv++; if (d !== 8'h0B || cyc != 11) begin nf++; $display("FAIL pend_latched data=%h cyc=%0d want 0B/11", d, cyc); end
      repeat (30) @(negedge clk);
      nv++; if (n_ack - s != 2) begin nf++; $display("FAIL pend_ack_count got %0d want 2", n_ack - s); end
      nv++; if (viol != 0 || prog_ba !== 2'd2) begin nf++; $display("FAIL single_outstanding viol=%0d ba=%0d want 0/2", viol, prog_ba); end
   endtask
   initial begin
      test_reset;
      test_miss;
      test_hits;
      test_oor;
      test_ram_off;
      test_drop;
      test_pend;
      $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
      $finish;
   end
endmodule
